// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU slices and the control unit.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_SLT = 3'b111;
  localparam alu_op_t ALU_NOR = 3'b101;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used by each ALU slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/one_bit_alu.sv
// Single-bit ALU slice: combinational result/carry/flags plus registered result and carry.
module one_bit_alu
  import alu_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  output logic    ri,
  output logic    ci_1,
  input  logic    ai,
  input  logic    bi,
  input  logic    ci,
  input  alu_op_t aluOp,
  input  logic    lessi,
  output logic    set,
  output logic    ovf,
  output logic    ri_q,
  output logic    ci_1_q
);

  logic b_mux;

  // aluOp[2] selects the inverted operand for SUB/SLT (and NOR, whose result ignores it).
  assign b_mux = bi ^ aluOp[2];

  full_adder u_full_adder (
    .a    (ai),
    .b    (b_mux),
    .cin  (ci),
    .sum  (set),
    .cout (ci_1)
  );

  assign ovf = ci ^ ci_1;

  always_comb begin
    ri = 1'b0;
    case (aluOp)
      ALU_AND: ri = ai & bi;
      ALU_OR:  ri = ai | bi;
      ALU_ADD: ri = set;
      ALU_SUB: ri = set;
      ALU_SLT: ri = lessi;
      ALU_NOR: ri = ~(ai | bi);
      default: ri = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ri_q   <= 1'b0;
      ci_1_q <= 1'b0;
    end else begin
      ri_q   <= ri;
      ci_1_q <= ci_1;
    end
  end

endmodule

// File: tb/tb_one_bit_alu.sv
// Directed self-checking bench for one_bit_alu.
module tb_one_bit_alu;

  logic       clk;
  logic       rst;
  logic       ri;
  logic       ci_1;
  logic       ai;
  logic       bi;
  logic       ci;
  logic [2:0] aluOp;
  logic       lessi;
  logic       set;
  logic       ovf;
  logic       ri_q;
  logic       ci_1_q;

  int tests;
  int fails;

  one_bit_alu dut (
    .clk    (clk),
    .rst    (rst),
    .ri     (ri),
    .ci_1   (ci_1),
    .ai     (ai),
    .bi     (bi),
    .ci     (ci),
    .aluOp  (aluOp),
    .lessi  (lessi),
    .set    (set),
    .ovf    (ovf),
    .ri_q   (ri_q),
    .ci_1_q (ci_1_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive a vector, settle, then check ri and ci_1.
  task automatic vec(input string tag, input logic [2:0] op, input logic a, input logic b,
                     input logic c, input logic l, input logic exp_ri, input logic exp_c1);
    aluOp = op;
    ai    = a;
    bi    = b;
    ci    = c;
    lessi = l;
    #1;
    chk({tag, ".ri"}, ri, exp_ri);
    chk({tag, ".ci_1"}, ci_1, exp_c1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    ai    = 1'b0;
    bi    = 1'b0;
    ci    = 1'b0;
    lessi = 1'b0;
    aluOp = 3'b000;
    #1;
    chk("reset.ri_q", ri_q, 1'b0);
    chk("reset.ci_1_q", ci_1_q, 1'b0);

    // Logic ops, ci=0
    vec("and00", 3'b000, 0, 0, 0, 0, 0, 0);
    vec("and01", 3'b000, 0, 1, 0, 0, 0, 0);
    vec("and10", 3'b000, 1, 0, 0, 0, 0, 0);
    vec("and11", 3'b000, 1, 1, 0, 0, 1, 1);
    vec("or00",  3'b001, 0, 0, 0, 0, 0, 0);
    vec("or01",  3'b001, 0, 1, 0, 0, 1, 0);
    vec("or10",  3'b001, 1, 0, 0, 0, 1, 0);
    vec("or11",  3'b001, 1, 1, 0, 0, 1, 1);
    // NOR result uses true bi, but the adder sees inverted bi
    vec("nor00", 3'b101, 0, 0, 0, 0, 1, 0);
    vec("nor01", 3'b101, 0, 1, 0, 0, 0, 0);
    vec("nor10", 3'b101, 1, 0, 0, 0, 0, 1);
    vec("nor11", 3'b101, 1, 1, 0, 0, 0, 0);
    vec("or10c1", 3'b001, 1, 0, 1, 0, 1, 1);

    // ADD, all (ai,bi,ci)
    vec("add000", 3'b010, 0, 0, 0, 0, 0, 0);
    vec("add001", 3'b010, 0, 0, 1, 0, 1, 0);
    vec("add010", 3'b010, 0, 1, 0, 0, 1, 0);
    vec("add011", 3'b010, 0, 1, 1, 0, 0, 1);
    vec("add100", 3'b010, 1, 0, 0, 0, 1, 0);
    vec("add101", 3'b010, 1, 0, 1, 0, 0, 1);
    vec("add110", 3'b010, 1, 1, 0, 0, 0, 1);
    vec("add111", 3'b010, 1, 1, 1, 0, 1, 1);

    // SUB, ci=1: a + ~b + 1
    vec("sub00", 3'b110, 0, 0, 1, 0, 0, 1);
    vec("sub01", 3'b110, 0, 1, 1, 0, 1, 0);
    vec("sub11", 3'b110, 1, 1, 1, 0, 0, 1);
    vec("sub10", 3'b110, 1, 0, 1, 0, 1, 1);

    // SLT, ci=0: ri follows lessi, ci_1 = ai & ~bi
    vec("slt00l0", 3'b111, 0, 0, 0, 0, 0, 0);
    vec("slt01l0", 3'b111, 0, 1, 0, 0, 0, 0);
    vec("slt10l0", 3'b111, 1, 0, 0, 0, 0, 1);
    vec("slt11l0", 3'b111, 1, 1, 0, 0, 0, 0);
    vec("slt00l1", 3'b111, 0, 0, 0, 1, 1, 0);
    vec("slt01l1", 3'b111, 0, 1, 0, 1, 1, 0);
    vec("slt10l1", 3'b111, 1, 0, 0, 1, 1, 1);
    vec("slt11l1", 3'b111, 1, 1, 0, 1, 1, 0);

    // Flags
    vec("addovf", 3'b010, 1, 1, 0, 0, 0, 1);
    chk("addovf.set", set, 1'b0);
    chk("addovf.ovf", ovf, 1'b1);
    vec("subovf", 3'b110, 0, 1, 1, 0, 1, 0);
    chk("subovf.set", set, 1'b1);
    chk("subovf.ovf", ovf, 1'b1);
    vec("add000f", 3'b010, 0, 0, 0, 0, 0, 0);
    chk("add000f.ovf", ovf, 1'b0);

    // Reserved ops: ri=0, carry still from adder with inverted-by-aluOp[2] b
    vec("rsv011", 3'b011, 1, 1, 0, 1, 0, 1);
    vec("rsv100", 3'b100, 1, 0, 0, 1, 0, 1);
    vec("rsv100b", 3'b100, 0, 1, 1, 1, 0, 0);

    // Registered path
    @(negedge clk);
    rst = 1'b0;
    vec("regadd100", 3'b010, 1, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("reg1.ri_q", ri_q, 1'b1);
    chk("reg1.ci_1_q", ci_1_q, 1'b0);
    @(negedge clk);
    vec("regadd110", 3'b010, 1, 1, 0, 0, 0, 1);
    chk("reg2pre.ri_q", ri_q, 1'b1);
    @(posedge clk);
    #1;
    chk("reg2.ri_q", ri_q, 1'b0);
    chk("reg2.ci_1_q", ci_1_q, 1'b1);
    @(negedge clk);
    vec("regand11", 3'b000, 1, 1, 0, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("reg3.ri_q", ri_q, 1'b1);
    chk("reg3.ci_1_q", ci_1_q, 1'b1);

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("rstasync.ri_q", ri_q, 1'b0);
    chk("rstasync.ci_1_q", ci_1_q, 1'b0);
    chk("rstasync.ri", ri, 1'b1);
    chk("rstasync.ci_1", ci_1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rsthold.ri_q", ri_q, 1'b0);
    chk("rsthold.ci_1_q", ci_1_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstrel.ri_q", ri_q, 1'b0);
    @(posedge clk);
    #1;
    chk("reload.ri_q", ri_q, 1'b1);
    chk("reload.ci_1_q", ci_1_q, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
